key_scan_entry: RTL and testbench

4x4 matrix keypad scanner with debounce and BCD time entry for the clock's set mode. It drives the keypad rows, samples the columns on the shared scan tick, and reports each debounced press as a key code pulse. In set mode it builds an HH:MM value on `set_h`/`set_m`, which the display scanner shows live, and pulses `set_done` on commit. It sits between the board keypad pins and the time-keeping/display blocks.

---
 rtl/key_pkg.sv | 54 +++++
 rtl/time_entry.sv | 73 +++++++
 rtl/key_scan_entry.sv | 111 +++++++++++
 tb/tb_key_scan_entry.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and keypad constants for the keypad scanner and the BCD time entry buffer.
package key_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_REL
    } scan_state_t;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_BS  = 4'hE;
    localparam logic [3:0] KEY_OK  = 4'hF;

    // Physical keypad layout: {row index, col index} -> key code
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic single_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

endpackage

// File: rtl/time_entry.sv
// BCD HH:MM entry buffer driven by accepted key presses, with hour/minute validity rules.
module time_entry
    import key_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       entry_en,
    output logic [7:0] set_h,
    output logic [7:0] set_m,
    output logic [2:0] digit_idx,
    output logic       set_done
);

    logic [3:0] dig_reg [0:3];
    logic       entry_en_reg;
    logic       digit_ok;

    assign set_h = {dig_reg[0], dig_reg[1]};
    assign set_m = {dig_reg[2], dig_reg[3]};

    always_comb begin
        digit_ok = 1'b0;
        if (key_code <= 4'd9) begin
            case (digit_idx)
                3'd0:    digit_ok = (key_code <= 4'd2);
                3'd1:    digit_ok = (dig_reg[0] == 4'd2) ? (key_code <= 4'd3) : 1'b1;
                3'd2:    digit_ok = (key_code <= 4'd5);
                3'd3:    digit_ok = 1'b1;
                default: digit_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) dig_reg[i] <= 4'd0;
            entry_en_reg <= 1'b0;
            digit_idx    <= 3'd0;
            set_done     <= 1'b0;
        end else begin
            set_done     <= 1'b0;
            entry_en_reg <= entry_en;
            if (entry_en_reg && !entry_en) begin
                digit_idx <= 3'd0;
            end else if (entry_en && key_valid) begin
                if (digit_ok) begin
                    // A fresh hour-tens digit starts a new value
                    if (digit_idx == 3'd0) begin
                        dig_reg[0] <= key_code;
                        dig_reg[1] <= 4'd0;
                        dig_reg[2] <= 4'd0;
                        dig_reg[3] <= 4'd0;
                    end else begin
                        dig_reg[digit_idx[1:0]] <= key_code;
                    end
                    digit_idx <= digit_idx + 3'd1;
                end else if (key_code == KEY_CLR) begin
                    for (int i = 0; i < 4; i++) dig_reg[i] <= 4'd0;
                    digit_idx <= 3'd0;
                end else if (key_code == KEY_BS && digit_idx != 3'd0) begin
                    dig_reg[2'(digit_idx - 3'd1)] <= 4'd0;
                    digit_idx <= digit_idx - 3'd1;
                end else if (key_code == KEY_OK && digit_idx == 3'd4) begin
                    set_done  <= 1'b1;
                    digit_idx <= 3'd0;
                end
            end
        end
    end

endmodule

// File: rtl/key_scan_entry.sv
// 4x4 keypad row scanner with column synchronizer and press/release debounce,
// feeding the BCD time entry buffer.
module key_scan_entry
    import key_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       entry_en,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [7:0] set_h,
    output logic [7:0] set_m,
    output logic [2:0] digit_idx,
    output logic       set_done
);

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_TICKS - 1);
    localparam logic [3:0] DEB_FULL = 4'(DEBOUNCE_TICKS);

    logic [3:0]  col_meta_reg;
    logic [3:0]  col_sync_reg;
    scan_state_t state_reg;
    logic [3:0]  cnt_reg;
    logic [3:0]  pattern_reg;
    logic [3:0]  row_rot;
    logic [3:0]  code_next;

    assign row_rot   = {row[2:0], row[3]};
    assign code_next = keymap(low_index(row), low_index(pattern_reg));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_meta_reg <= 4'hF;
            col_sync_reg <= 4'hF;
            state_reg    <= SCAN;
            row          <= 4'b1110;
            cnt_reg      <= 4'd0;
            pattern_reg  <= 4'hF;
            key_code     <= 4'd0;
            key_valid    <= 1'b0;
        end else begin
            col_meta_reg <= col;
            col_sync_reg <= col_meta_reg;
            key_valid    <= 1'b0;
            if (enable) begin
                case (state_reg)
                    SCAN: begin
                        if (single_low(col_sync_reg)) begin
                            pattern_reg <= col_sync_reg;
                            cnt_reg     <= 4'd0;
                            state_reg   <= DEB_PRESS;
                        end else begin
                            // idle or ghosting multi-key pattern: keep scanning
                            row <= row_rot;
                        end
                    end
                    DEB_PRESS: begin
                        if (col_sync_reg == pattern_reg) begin
                            if (cnt_reg == DEB_LAST) begin
                                cnt_reg   <= DEB_FULL;
                                key_code  <= code_next;
                                key_valid <= 1'b1;
                                state_reg <= HELD;
                            end else begin
                                cnt_reg <= cnt_reg + 4'd1;
                            end
                        end else begin
                            state_reg <= SCAN;
                            row       <= row_rot;
                        end
                    end
                    HELD: begin
                        if (col_sync_reg == 4'hF) begin
                            cnt_reg   <= 4'd0;
                            state_reg <= DEB_REL;
                        end
                    end
                    default: begin
                        if (col_sync_reg != 4'hF) begin
                            state_reg <= HELD;
                        end else if (cnt_reg == DEB_LAST) begin
                            cnt_reg   <= DEB_FULL;
                            state_reg <= SCAN;
                            row       <= row_rot;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    time_entry u_entry (
        .clk       (clk),
        .rstn      (rstn),
        .key_code  (key_code),
        .key_valid (key_valid),
        .entry_en  (entry_en),
        .set_h     (set_h),
        .set_m     (set_m),
        .digit_idx (digit_idx),
        .set_done  (set_done)
    );

endmodule

// File: tb/tb_key_scan_entry.sv
// Directed bench for key_scan_entry: keypad model on row/col, scan/debounce timing and BCD entry.
module tb_key_scan_entry;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       enable   = 1'b0;
    logic       entry_en = 1'b0;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic [7:0] set_h;
    logic [7:0] set_m;
    logic [2:0] digit_idx;
    logic       set_done;

    logic       pressed    = 1'b0;
    logic [1:0] press_r    = 2'd0;
    logic [3:0] press_mask = 4'd0;

    int tests    = 0;
    int fails    = 0;
    int kv_count = 0;
    int sd_count = 0;

    key_scan_entry #(.DEBOUNCE_TICKS(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .entry_en  (entry_en),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .set_h     (set_h),
        .set_m     (set_m),
        .digit_idx (digit_idx),
        .set_done  (set_done)
    );

    // Keypad: pressed columns pull low only while their row is driven low
    assign col = (pressed && !row[press_r]) ? ~press_mask : 4'hF;

    always #5 clk = ~clk;

    // One-clk scan tick every 4 clk
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 enable = 1'b1;
            @(posedge clk);
            #1 enable = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (key_valid) kv_count <= kv_count + 1;
        if (set_done)  sd_count <= sd_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_tick();
        @(posedge clk);
        while (!enable) @(posedge clk);
        #2;
    endtask

    // {row index, col index} of a key code
    function automatic logic [3:0] key_pos(input logic [3:0] code);
        case (code)
            4'h1: return 4'b0000;
            4'h2: return 4'b0001;
            4'h3: return 4'b0010;
            4'hA: return 4'b0011;
            4'h4: return 4'b0100;
            4'h5: return 4'b0101;
            4'h6: return 4'b0110;
            4'hB: return 4'b0111;
            4'h7: return 4'b1000;
            4'h8: return 4'b1001;
            4'h9: return 4'b1010;
            4'hC: return 4'b1011;
            4'hE: return 4'b1100;
            4'h0: return 4'b1101;
            4'hF: return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic aim_key(input logic [3:0] code);
        logic [3:0] p;
        p = key_pos(code);
        press_r    = p[3:2];
        press_mask = 4'b0001 << p[1:0];
    endtask

    task automatic wait_kv(input int kv0);
        for (int i = 0; i < 60 && kv_count == kv0; i++) next_tick();
    endtask

    task automatic press_key(input logic [3:0] code);
        int kv0;
        kv0 = kv_count;
        aim_key(code);
        pressed = 1'b1;
        wait_kv(kv0);
        check("kv_seen", kv_count - kv0, 1);
        check("key_code", 32'(key_code), 32'(code));
        pressed = 1'b0;
        repeat (10) next_tick();
        $display("[TB] key %h: set_h=%h set_m=%h idx=%0d", code, set_h, set_m, digit_idx);
    endtask

    // Press aligned to the tick where the key's row becomes active; checks exact latency
    task automatic timed_press(input logic [3:0] code);
        int kv0;
        kv0 = kv_count;
        aim_key(code);
        for (int i = 0; i < 8; i++) begin
            next_tick();
            if (row[press_r] === 1'b0) break;
        end
        pressed = 1'b1;
        repeat (4) next_tick();
        check("lat_early", kv_count - kv0, 0);
        next_tick();
        check("lat_pulse", 32'(key_valid), 1);
        check("lat_code", 32'(key_code), 32'(code));
        pressed = 1'b0;
        repeat (10) next_tick();
        $display("[TB] timed key %h: code=%h", code, key_code);
    endtask

    initial begin
        logic [3:0] exp_row;
        int kv0;
        int sd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_row", 32'(row), 32'hE);
        check("rst_code", 32'(key_code), 0);
        check("rst_kv", 32'(key_valid), 0);
        check("rst_set_h", 32'(set_h), 0);
        check("rst_set_m", 32'(set_m), 0);
        check("rst_idx", 32'(digit_idx), 0);
        check("rst_done", 32'(set_done), 0);
        next_tick();
        rstn = 1'b1;

        // Idle rotation
        exp_row = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            next_tick();
            exp_row = {exp_row[2:0], exp_row[3]};
            check("idle_row", 32'(row), 32'(exp_row));
        end
        check("idle_kv", kv_count, 0);
        check("idle_set_h", 32'(set_h), 0);
        $display("[TB] idle rotation row=%b", row);

        // Key 8 with three bounce ticks
        kv0 = kv_count;
        aim_key(4'h8);
        for (int i = 0; i < 3; i++) begin
            pressed = 1'b1;
            next_tick();
            pressed = 1'b0;
            next_tick();
        end
        pressed = 1'b1;
        wait_kv(kv0);
        check("bounce_kv", kv_count - kv0, 1);
        check("bounce_code", 32'(key_code), 32'h8);
        repeat (8) next_tick();
        pressed = 1'b0;
        repeat (10) next_tick();
        check("bounce_once", kv_count - kv0, 1);
        check("bounce_no_entry", 32'(set_h), 0);
        $display("[TB] bounced key 8: pulses=%0d", kv_count - kv0);

        // Exact debounce latency
        timed_press(4'h5);

        // Two columns low on row 0: ignored, rotation continues
        kv0 = kv_count;
        press_r    = 2'd0;
        press_mask = 4'b0011;
        pressed    = 1'b1;
        exp_row    = row;
        for (int i = 0; i < 6; i++) begin
            next_tick();
            exp_row = {exp_row[2:0], exp_row[3]};
            check("dual_row", 32'(row), 32'(exp_row));
        end
        check("dual_kv", kv_count - kv0, 0);
        pressed = 1'b0;
        repeat (2) next_tick();
        $display("[TB] dual-column press ignored");

        // Full entry 23:59 and commit
        entry_en = 1'b1;
        press_key(4'h2);
        check("e2_h", 32'(set_h), 32'h20);
        check("e2_m", 32'(set_m), 32'h00);
        press_key(4'h3);
        check("e3_h", 32'(set_h), 32'h23);
        check("e3_m", 32'(set_m), 32'h00);
        press_key(4'h5);
        check("e5_h", 32'(set_h), 32'h23);
        check("e5_m", 32'(set_m), 32'h50);
        press_key(4'h9);
        check("e9_m", 32'(set_m), 32'h59);
        check("e9_idx", 32'(digit_idx), 4);
        sd0 = sd_count;
        press_key(4'hF);
        check("ok_done", sd_count - sd0, 1);
        check("ok_idx", 32'(digit_idx), 0);
        check("ok_h_held", 32'(set_h), 32'h23);
        check("ok_m_held", 32'(set_m), 32'h59);

        // Rejections, clear and backspace
        press_key(4'hA);
        check("clr_h", 32'(set_h), 0);
        check("clr_m", 32'(set_m), 0);
        check("clr_idx", 32'(digit_idx), 0);
        press_key(4'h2);
        press_key(4'h4);
        check("rej24_h", 32'(set_h), 32'h20);
        check("rej24_idx", 32'(digit_idx), 1);
        press_key(4'hE);
        check("bs_h", 32'(set_h), 0);
        check("bs_idx", 32'(digit_idx), 0);
        press_key(4'h1);
        press_key(4'h2);
        press_key(4'h6);
        check("rej6_m", 32'(set_m), 0);
        check("rej6_idx", 32'(digit_idx), 2);
        sd0 = sd_count;
        press_key(4'hF);
        check("ok_early_done", sd_count - sd0, 0);
        check("ok_early_idx", 32'(digit_idx), 2);
        check("pre_rst_h", 32'(set_h), 32'h12);

        // Reset during press debounce
        aim_key(4'h1);
        for (int i = 0; i < 8; i++) begin
            next_tick();
            if (row[press_r] === 1'b0) break;
        end
        pressed = 1'b1;
        repeat (2) next_tick();
        rstn = 1'b0;
        #1;
        check("mid_rst_row", 32'(row), 32'hE);
        check("mid_rst_code", 32'(key_code), 0);
        check("mid_rst_kv", 32'(key_valid), 0);
        check("mid_rst_h", 32'(set_h), 0);
        check("mid_rst_m", 32'(set_m), 0);
        check("mid_rst_idx", 32'(digit_idx), 0);
        check("mid_rst_done", 32'(set_done), 0);
        next_tick();
        rstn = 1'b1;
        kv0 = kv_count;
        repeat (4) next_tick();
        check("rerun_early", kv_count - kv0, 0);
        next_tick();
        check("rerun_pulse", 32'(key_valid), 1);
        check("rerun_code", 32'(key_code), 32'h1);
        pressed = 1'b0;
        repeat (10) next_tick();
        check("rerun_h", 32'(set_h), 32'h10);
        check("rerun_idx", 32'(digit_idx), 1);
        $display("[TB] reset mid-debounce, re-debounced key 1: set_h=%h", set_h);

        // Leaving set mode: idx to 0, digits held, keys still reported
        entry_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("exit_idx", 32'(digit_idx), 0);
        check("exit_h", 32'(set_h), 32'h10);
        press_key(4'h3);
        check("off_h", 32'(set_h), 32'h10);
        check("off_idx", 32'(digit_idx), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
